// File: rtl/std_dff_r.sv
// -----------------------------------------------------------------------------
// std_dff_r
//   Generic resettable register stage, WIDTH bits wide, STAGES deep.
//   Used for registering handshake strobes and state. For example, chained
//   1-bit stages produce the hsk_ff / hsk_ff_ff delays in the snoop unit.
//   All stages share one synchronous reset that loads RESET_VAL.
//
// Parameters
//   WIDTH     : data width in bits (>= 1)
//   STAGES    : number of register stages between d and q (>= 1)
//   RESET_VAL : value loaded into every stage on reset (WIDTH bits)
//
// Ports
//   clk  : rising-edge clock, the only clock
//   rstn : synchronous reset, ACTIVE-HIGH despite the legacy name
//   d    : data input
//   q    : data output, taken from the last stage
// -----------------------------------------------------------------------------
module std_dff_r #(
    parameter int                 WIDTH     = 1,
    parameter int                 STAGES    = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reject illegal shapes at elaboration instead of building a degenerate
    // register array.
    if (WIDTH < 1 || STAGES < 1) begin : g_param_err
        $error("std_dff_r: WIDTH (%0d) and STAGES (%0d) must both be >= 1",
               WIDTH, STAGES);
    end

    // Stage 0 faces d and stage STAGES-1 drives q.
    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    // A reset edge discards every in-flight value. Reset takes priority over
    // the shift, so d is ignored on that edge.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

endmodule

// File: tb/tb_std_dff_r.sv
module tb_std_dff_r;

    localparam int RS = 4;  // depth of the randomized instance

    logic clk;
    int   checks = 0;
    int   errors = 0;

    // Each instance has its own stimulus.
    logic       r1;  logic       d1;  logic       q1;   // W1 S1
    logic       r8;  logic [7:0] d8;  logic [7:0] q8;   // W8 S1
    logic       r2;  logic       d2;  logic       q2;   // W1 S2
    logic       r3;  logic [3:0] d3;  logic [3:0] q3;   // W4 S3 RV0
    logic       r5;  logic [3:0] d5;  logic [3:0] q5;   // W4 S1 RV C
    logic       rr;  logic [7:0] dr;  logic [7:0] qr;   // W8 S4 RV 3C

    std_dff_r #(.WIDTH(1), .STAGES(1)) u1 (.clk(clk), .rstn(r1), .d(d1), .q(q1));
    std_dff_r #(.WIDTH(8), .STAGES(1)) u8 (.clk(clk), .rstn(r8), .d(d8), .q(q8));
    std_dff_r #(.WIDTH(1), .STAGES(2)) u2 (.clk(clk), .rstn(r2), .d(d2), .q(q2));
    std_dff_r #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'h0)) u3 (.clk(clk), .rstn(r3), .d(d3), .q(q3));
    std_dff_r #(.WIDTH(4), .STAGES(1), .RESET_VAL(4'hC)) u5 (.clk(clk), .rstn(r5), .d(d5), .q(q5));
    std_dff_r #(.WIDTH(8), .STAGES(RS), .RESET_VAL(8'h3C)) ur (.clk(clk), .rstn(rr), .d(dr), .q(qr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus changes at posedge+1. Outputs are sampled at the same point,
    // before new inputs are applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference for the random instance: the (reset, data) pair applied at each edge.
    logic       hr [0:1023];
    logic [7:0] hd [0:1023];

    initial begin
        logic [7:0] exp_r;
        logic       rst_seen;

        // Global reset. All data inputs are nonzero so a leak would show.
        r1 = 1; r8 = 1; r2 = 1; r3 = 1; r5 = 1; rr = 1;
        d1 = 1; d8 = 8'hFF; d2 = 1; d3 = 4'hF; d5 = 4'hF; dr = 8'hFF;
        tick(); tick();
        check("rst_w1_2edges", 32'(q1), 32'd0);
        check("rst_w4_val_C",  32'(q5), 32'hC);
        tick(); tick();
        check("rst_w1_held",   32'(q1), 32'd0);
        check("rst_w8",        32'(q8), 32'd0);
        check("rst_s2",        32'(q2), 32'd0);
        check("rst_s3",        32'(q3), 32'd0);
        check("rst_rand_inst", 32'(qr), 32'h3C);

        // 1. Release reset on a 1-bit single stage.
        r1 = 0; d1 = 1; tick();
        check("w1_release_d1", 32'(q1), 32'd1);
        d1 = 0; tick();
        check("w1_d0", 32'(q1), 32'd0);
        r1 = 1; d1 = 1; tick();
        check("w1_reset_prio", 32'(q1), 32'd0);

        // 2. Byte-wide data passes through with one-cycle latency.
        r8 = 0; d8 = 8'hA5; tick();
        check("w8_A5", 32'(q8), 32'hA5);
        d8 = 8'h5A; tick();
        check("w8_5A", 32'(q8), 32'h5A);

        // 3. Two-stage chain: a one-cycle pulse shows up one edge later, for one cycle.
        r2 = 0; d2 = 0; tick(); tick();
        check("s2_idle", 32'(q2), 32'd0);
        d2 = 1; tick();                       // pulse sampled at edge n
        check("s2_edge_n", 32'(q2), 32'd0);
        d2 = 0; tick();                       // edge n+1
        check("s2_edge_n1", 32'(q2), 32'd1);
        tick();                               // edge n+2
        check("s2_edge_n2", 32'(q2), 32'd0);

        // 4. Three-stage pipeline reset while 1,2,3 are in flight.
        r3 = 0; d3 = 4'd1; tick();
        check("s3_fill1", 32'(q3), 32'd0);
        d3 = 4'd2; tick();
        check("s3_fill2", 32'(q3), 32'd0);
        d3 = 4'd3; r3 = 1; tick();
        check("s3_midreset", 32'(q3), 32'd0);
        r3 = 0; d3 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3_flushed", 32'(q3), 32'd0);
        end

        // 5. Nonzero reset value, then release.
        d5 = 4'h3; tick();
        check("rv_C_held", 32'(q5), 32'hC);
        r5 = 0; tick();
        check("rv_release_3", 32'(q5), 32'h3);

        // 6. Random data with about 5% reset. The expected value is derived
        //    from the history: q after edge n equals d from edge n-RS+1,
        //    unless any edge in that window had reset asserted.
        for (int n = 0; n < 1000; n++) begin
            rr = (n < RS) ? 1'b1 : ($urandom_range(0, 99) < 5);
            dr = 8'($urandom);
            hr[n] = rr;
            hd[n] = dr;
            tick();
            exp_r = 8'h3C;
            if (n >= RS - 1) begin
                rst_seen = 1'b0;
                for (int k = n - RS + 1; k <= n; k++) begin
                    if (hr[k]) rst_seen = 1'b1;
                end
                if (!rst_seen) exp_r = hd[n - RS + 1];
            end
            check("random_pipe", 32'(qr), 32'(exp_r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
